// File: rtl/rom_upload_pkg.sv
// Shared types and helpers for the ROM/NVRAM upload read-back path.
package rom_upload_pkg;

    localparam int WORD_AW = 23;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        PREF
    } state_t;

    // Byte address bit 0 picks the lane, matching the download write path.
    function automatic logic [7:0] lane_select(input logic [15:0] word, input logic hi_lane);
        return hi_lane ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/sdram_toggle_master.sv
// Toggle req/ack master for one SDRAM port: owns port_req, the address/strobe registers and the done pulse.
module sdram_toggle_master
    import rom_upload_pkg::*;
(
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               start,
    input  logic [WORD_AW-1:0] start_a,
    input  logic [1:0]         start_ds,
    input  logic               port_ack,
    output logic               port_req,
    output logic [WORD_AW-1:0] port_a,
    output logic [1:0]         port_ds,
    output logic               busy,
    output logic               done
);

    logic in_flight;

    assign busy = port_req != port_ack;
    // in_flight masks the equality seen after a reset with a stale ack.
    assign done = in_flight & ~busy;

    // NOTE: every register here is sequential state, so it is assigned with <= only;
    // blocking assignments would make the order of these lines observable.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            port_req  <= 1'b0;
            port_a    <= '0;
            port_ds   <= '0;
            in_flight <= 1'b0;
        end else if (start && !busy) begin
            port_req  <= ~port_req;
            port_a    <= start_a;
            port_ds   <= start_ds;
            in_flight <= 1'b1;
        end else if (done) begin
            in_flight <= 1'b0;
        end
    end

endmodule

// File: rtl/rom_upload_reader.sv
// Upload read-back engine: serves ioctl byte reads from a one-word cache backed by an SDRAM port.
// Optional next-word prefetch is enabled by defining ROM_UPLOAD_PREFETCH_EN.
module rom_upload_reader
    import rom_upload_pkg::*;
#(
    parameter int             AW        = 25,
    parameter logic [AW-1:0]  BASE_ADDR = '0
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               upload,
    input  logic               ioctl_rd,
    input  logic [AW-1:0]      ioctl_addr,
    output logic [7:0]         ioctl_din,
    output logic               ioctl_ready,
    output logic               rd_err,
    output logic               port_req,
    input  logic               port_ack,
    output logic [WORD_AW-1:0] port_a,
    output logic [1:0]         port_ds,
    output logic               port_we,
    input  logic [15:0]        port_q
);

    localparam int BAW = WORD_AW + 1;

    state_t             state;
    logic               upload_q;
    logic               upload_rise;
    logic               upload_fall;
    logic               rd_acc;
    logic [BAW-1:0]     rd_byte;
    logic               pend_valid;
    logic [BAW-1:0]     pend_byte;
    logic               req_valid;
    logic [BAW-1:0]     req_byte;
    logic [WORD_AW-1:0] req_word;
    logic               req_hi;
    logic               c_valid;
    logic [WORD_AW-1:0] c_addr;
    logic [15:0]        c_data;
    logic               cache_hit;
    logic               fetch_hi;
    logic               tm_start;
    logic [WORD_AW-1:0] tm_a;
    logic [1:0]         tm_ds;
    logic               busy;
    logic               done;
    logic               launch;
`ifdef ROM_UPLOAD_PREFETCH_EN
    logic               p_valid;
    logic [WORD_AW-1:0] p_addr;
    logic [15:0]        p_data;
    logic               pref_hit;
`endif

    assign port_we     = 1'b0;
    assign upload_rise = upload & ~upload_q;
    assign upload_fall = upload_q & ~upload;
    assign rd_acc      = ioctl_rd & upload;
    assign rd_byte     = BAW'(ioctl_addr - BASE_ADDR);

    // A fresh strobe takes precedence over the slot it would overwrite.
    assign req_valid = rd_acc | pend_valid;
    assign req_byte  = rd_acc ? rd_byte : pend_byte;
    assign req_word  = req_byte[BAW-1:1];
    assign req_hi    = req_byte[0];
    assign cache_hit = c_valid && (c_addr == req_word);
`ifdef ROM_UPLOAD_PREFETCH_EN
    assign pref_hit  = p_valid && (p_addr == req_word);
`endif

    // NOTE: defaults first so every path assigns every output; no latches are inferred.
    always_comb begin
        tm_start = 1'b0;
        tm_a     = req_word;
        tm_ds    = {req_hi, ~req_hi};
        case (state)
            IDLE: begin
                if (req_valid && !cache_hit) begin
`ifdef ROM_UPLOAD_PREFETCH_EN
                    tm_start = 1'b1;
                    if (pref_hit) begin
                        tm_a  = p_addr + WORD_AW'(1);
                        tm_ds = 2'b11;
                    end
`else
                    tm_start = 1'b1;
`endif
                end
            end
`ifdef ROM_UPLOAD_PREFETCH_EN
            FETCH: begin
                if (done) begin
                    tm_start = 1'b1;
                    tm_a     = port_a + WORD_AW'(1);
                    tm_ds    = 2'b11;
                end
            end
`endif
            default: tm_start = 1'b0;
        endcase
        if (upload_fall) tm_start = 1'b0;
    end

    assign launch = tm_start & ~busy;

    sdram_toggle_master u_master (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .start    (tm_start),
        .start_a  (tm_a),
        .start_ds (tm_ds),
        .port_ack (port_ack),
        .port_req (port_req),
        .port_a   (port_a),
        .port_ds  (port_ds),
        .busy     (busy),
        .done     (done)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            upload_q    <= 1'b0;
            ioctl_din   <= '0;
            ioctl_ready <= 1'b0;
            rd_err      <= 1'b0;
            pend_valid  <= 1'b0;
            pend_byte   <= '0;
            c_valid     <= 1'b0;
            c_addr      <= '0;
            c_data      <= '0;
            fetch_hi    <= 1'b0;
`ifdef ROM_UPLOAD_PREFETCH_EN
            p_valid     <= 1'b0;
            p_addr      <= '0;
            p_data      <= '0;
`endif
        end else begin
            upload_q <= upload;
            if (upload_rise) rd_err <= 1'b0;

            if (upload_fall) begin
                c_valid     <= 1'b0;
                pend_valid  <= 1'b0;
                ioctl_ready <= 1'b0;
`ifdef ROM_UPLOAD_PREFETCH_EN
                p_valid     <= 1'b0;
`endif
                // An in-flight transfer still owes an ack; wait for it and drop the data.
                if (state == FETCH || state == PREF) state <= done ? IDLE : DRAIN;
            end else begin
                if (state != IDLE && rd_acc) begin
                    pend_valid <= 1'b1;
                    pend_byte  <= rd_byte;
                    if (pend_valid) rd_err <= 1'b1;
                end

                case (state)
                    IDLE: begin
                        if (rd_acc && pend_valid) rd_err <= 1'b1;
                        if (req_valid) begin
                            if (cache_hit) begin
                                ioctl_din   <= lane_select(c_data, req_hi);
                                ioctl_ready <= 1'b1;
                                pend_valid  <= 1'b0;
`ifdef ROM_UPLOAD_PREFETCH_EN
                            end else if (pref_hit) begin
                                c_addr      <= p_addr;
                                c_data      <= p_data;
                                c_valid     <= 1'b1;
                                p_valid     <= 1'b0;
                                ioctl_din   <= lane_select(p_data, req_hi);
                                ioctl_ready <= 1'b1;
                                pend_valid  <= 1'b0;
                                if (launch) state <= PREF;
`endif
                            end else if (launch) begin
                                ioctl_ready <= 1'b0;
                                fetch_hi    <= req_hi;
                                pend_valid  <= 1'b0;
                                state       <= FETCH;
                            end else begin
                                // Port still owes an ack from before reset; park the request.
                                pend_valid <= 1'b1;
                                pend_byte  <= req_byte;
                            end
                        end
                    end
                    FETCH: begin
                        if (done) begin
                            c_addr      <= port_a;
                            c_data      <= port_q;
                            c_valid     <= 1'b1;
                            ioctl_din   <= lane_select(port_q, fetch_hi);
                            ioctl_ready <= 1'b1;
`ifdef ROM_UPLOAD_PREFETCH_EN
                            state       <= launch ? PREF : IDLE;
`else
                            state       <= IDLE;
`endif
                        end
                    end
`ifdef ROM_UPLOAD_PREFETCH_EN
                    PREF: begin
                        if (done) begin
                            p_addr  <= port_a;
                            p_data  <= port_q;
                            p_valid <= 1'b1;
                            state   <= IDLE;
                        end
                    end
`endif
                    default: begin
                        if (done) state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rom_upload_reader.sv
// Directed bench for rom_upload_reader: two instances (BASE_ADDR 0 and 0xC000) on behavioural SDRAM ports.
module tb_rom_upload_reader;

    logic        clk_sys;
    logic        reset;
    logic        upload;

    logic        rd0, rd1;
    logic [24:0] addr0, addr1;
    logic [7:0]  din0, din1;
    logic        ready0, ready1, err0, err1;
    logic        req0, req1, we0, we1;
    logic        ack0 = 1'b0, ack1 = 1'b0;
    logic [22:0] a0, a1;
    logic [1:0]  ds0, ds1;
    logic [15:0] q0 = '0, q1 = '0;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          ack_delay = 3;

    logic        req0_q = 1'b0;
    int          tog0 = 0, served0 = 0, dly0 = 0, dly1 = 0;
    logic [22:0] last_a0 = '0;
    logic [1:0]  last_ds0 = '0;

    rom_upload_reader #(.AW(25), .BASE_ADDR(25'h0)) dut0 (
        .clk_sys(clk_sys), .reset(reset), .upload(upload),
        .ioctl_rd(rd0), .ioctl_addr(addr0), .ioctl_din(din0), .ioctl_ready(ready0),
        .rd_err(err0), .port_req(req0), .port_ack(ack0), .port_a(a0), .port_ds(ds0),
        .port_we(we0), .port_q(q0)
    );

    rom_upload_reader #(.AW(25), .BASE_ADDR(25'hC000)) dut1 (
        .clk_sys(clk_sys), .reset(reset), .upload(upload),
        .ioctl_rd(rd1), .ioctl_addr(addr1), .ioctl_din(din1), .ioctl_ready(ready1),
        .rd_err(err1), .port_req(req1), .port_ack(ack1), .port_a(a1), .port_ds(ds1),
        .port_we(we1), .port_q(q1)
    );

    initial clk_sys = 1'b0;
    always #10 clk_sys = ~clk_sys;

    function automatic logic [15:0] mem_word(input logic [22:0] w);
        if (w == 23'd8) return 16'hBEEF;
        if (w == 23'd1) return 16'h1234;
        return {~w[7:0], w[7:0]};
    endfunction

    always @(posedge clk_sys) begin
        req0_q <= req0;
        if (req0 != req0_q) tog0 <= tog0 + 1;
        if (req0 != ack0) begin
            if (dly0 >= ack_delay) begin
                q0       <= mem_word(a0);
                ack0     <= req0;
                last_a0  <= a0;
                last_ds0 <= ds0;
                served0  <= served0 + 1;
                dly0     <= 0;
            end else begin
                dly0 <= dly0 + 1;
            end
        end
    end

    always @(posedge clk_sys) begin
        if (req1 != ack1) begin
            if (dly1 >= ack_delay) begin
                q1   <= mem_word(a1);
                ack1 <= req1;
                dly1 <= 0;
            end else begin
                dly1 <= dly1 + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic rd_pulse0(input logic [24:0] addr);
        rd0   = 1'b1;
        addr0 = addr;
        tick();
        rd0   = 1'b0;
    endtask

    task automatic rd_pulse1(input logic [24:0] addr);
        rd1   = 1'b1;
        addr1 = addr;
        tick();
        rd1   = 1'b0;
    endtask

    // Returns on the sample where the model has just acked word `addr`.
    task automatic wait_served0(input int base, input logic [22:0] addr, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (served0 != base && last_a0 == addr) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check(tag, 32'(found), 32'd1);
    endtask

    task automatic settle();
        for (int i = 0; i < 300; i++) begin
            if (req0 == ack0 && req1 == ack1) break;
            tick();
        end
        repeat (3) tick();
    endtask

    initial begin
        int   base;
        int   t;
        logic saw;

        reset = 1'b1;
        upload = 1'b0;
        rd0 = 1'b0; addr0 = '0;
        rd1 = 1'b0; addr1 = '0;
        repeat (3) tick();

        check("rst_din",   32'(din0),   32'h0);
        check("rst_ready", 32'(ready0), 32'h0);
        check("rst_err",   32'(err0),   32'h0);
        check("rst_req",   32'(req0),   32'h0);
        check("rst_a",     32'(a0),     32'h0);
        check("rst_ds",    32'(ds0),    32'h0);
        check("rst_we",    32'(we0),    32'h0);

        reset = 1'b0;
        tick();
        upload = 1'b1;
        repeat (2) tick();

        // Cold miss at byte 0x10 -> word 8 (0xBEEF), low lane.
        base = served0;
        rd_pulse0(25'h10);
        check("miss_req",   32'(req0),   32'h1);
        check("miss_ready", 32'(ready0), 32'h0);
        check("miss_a",     32'(a0),     32'h8);
        check("miss_ds",    32'(ds0),    32'h1);
        wait_served0(base, 23'd8, "miss_served");
        check("miss_ready_at_ack", 32'(ready0), 32'h0);
        tick();
        check("miss_ready_after", 32'(ready0), 32'h1);
        check("miss_din",         32'(din0),   32'hEF);
        check("miss_toggles",     32'(tog0),   32'd1);

        // Hit on the other lane of the cached word.
        settle();
        t = tog0;
        rd_pulse0(25'h11);
        check("hit_ready", 32'(ready0), 32'h1);
        check("hit_din",   32'(din0),   32'hBE);
        repeat (3) tick();
        check("hit_no_toggle", 32'(tog0 - t), 32'd0);

        // BASE_ADDR offset: 0xC003 -> word 1, upper lane of 0x1234.
        rd_pulse1(25'hC003);
        check("ofs_a",  32'(a1),  32'h1);
        check("ofs_ds", 32'(ds1), 32'h2);
        saw = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (ready1) begin
                saw = 1'b1;
                break;
            end
            tick();
        end
        check("ofs_ready", 32'(saw),  32'h1);
        check("ofs_din",   32'(din1), 32'h12);

        // Three reads while a slow fetch is in flight: last one wins, rd_err set.
        settle();
        ack_delay = 10;
        base = served0;
        rd_pulse0(25'h40);
        tick();
        rd_pulse0(25'h50);
        tick();
        rd_pulse0(25'h62);
        tick();
        rd_pulse0(25'h73);
        wait_served0(base, 23'h20, "ovf_first_served");
        tick();
        check("ovf_first_din", 32'(din0), 32'h20);
        wait_served0(base, 23'h39, "ovf_last_served");
        check("ovf_last_ds", 32'(last_ds0), 32'h2);
        tick();
        check("ovf_last_ready", 32'(ready0), 32'h1);
        check("ovf_last_din",   32'(din0),   32'hC6);
        check("ovf_err",        32'(err0),   32'h1);
        settle();
        upload = 1'b0;
        tick();
        check("ovf_err_held", 32'(err0), 32'h1);
        upload = 1'b1;
        tick();
        check("ovf_err_cleared", 32'(err0), 32'h0);

        // Abort: drop upload mid-fetch; the ack is consumed and ready stays low.
        rd_pulse0(25'h80);
        repeat (3) tick();
        upload = 1'b0;
        saw = 1'b0;
        repeat (30) begin
            tick();
            if (ready0) saw = 1'b1;
        end
        check("abort_ready", 32'(saw), 32'h0);
        check("abort_acked", 32'(req0 == ack0), 32'h1);
        upload = 1'b1;
        tick();
        t = tog0;
        base = served0;
        rd_pulse0(25'h80);
        wait_served0(base, 23'h40, "refetch_served");
        tick();
        check("refetch_ready",   32'(ready0),   32'h1);
        check("refetch_din",     32'(din0),     32'h40);
        check("refetch_toggles", 32'(tog0 - t), 32'd1);

`ifdef ROM_UPLOAD_PREFETCH_EN
        // Prefetch: word 1 is fetched behind word 0, then 0x02 hits it.
        settle();
        ack_delay = 3;
        upload = 1'b0;
        tick();
        upload = 1'b1;
        tick();
        base = served0;
        rd_pulse0(25'h00);
        wait_served0(base, 23'd0, "pf_w0_served");
        tick();
        check("pf_w0_din", 32'(din0), 32'h00);
        settle();
        check("pf_w1_fetched", 32'(last_a0), 32'h1);
        rd_pulse0(25'h01);
        check("pf_hit_din", 32'(din0), 32'hFF);
        rd_pulse0(25'h02);
        check("pf_promote_ready", 32'(ready0), 32'h1);
        check("pf_promote_din",   32'(din0),   32'h34);
        settle();
        check("pf_next_fetched", 32'(last_a0), 32'h2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_upload_reader.md
# rom_upload_reader

Read-back engine for the ROM/NVRAM upload path: services byte read requests from `data_io` during an upload by fetching 16-bit words from an SDRAM port through the toggle req/ack handshake, then returning the addressed byte. It mirrors the download write path and uses the same address mapping and byte-lane convention: byte address bit 0 selects the lane. It sits in the core top level between `data_io` (upload side) and a spare SDRAM controller port.

## Interface
Parameters:
- `AW`, 25: byte address width of `ioctl_addr`.
- `BASE_ADDR`, 25'h0: subtracted from `ioctl_addr` before mapping to the SDRAM word address.

Ports:
- `clk_sys`  in  1  system clock (the 49.152 MHz core clock).
- `reset`  in  1  asynchronous, active-high reset.
- `upload`  in  1  level; high while the host upload is active.
- `ioctl_rd`  in  1  single-cycle byte read strobe.
- `ioctl_addr`  in  AW  byte address, valid with `ioctl_rd`.
- `ioctl_din`  out  8  returned byte.
- `ioctl_ready`  out  1  high when `ioctl_din` is valid for the last accepted request.
- `rd_err`  out  1  sticky flag: a pending request was overwritten.
- `port_req`  out  1  toggle request to SDRAM.
- `port_ack`  in  1  toggle acknowledge; the transfer is complete when it equals `port_req`.
- `port_a`  out  23  word address, `(ioctl_addr-BASE_ADDR)[23:1]`.
- `port_ds`  out  2  `{eff[0], ~eff[0]}` of the demanded byte.
- `port_we`  out  1  constant 0.
- `port_q`  in  16  read data, valid when `port_ack` equals `port_req`.

## Operation
- Byte lanes: if `eff[0]` is 0, return `port_q[7:0]`; if 1, return `port_q[15:8]`.
- Cache: one word entry holding `c_addr[22:0]`, `c_data[15:0]` and `c_valid`.
- States:
  - IDLE: waiting for a request.
  - FETCH: demand fetch in flight.
  - DRAIN: fetch in flight whose data will be discarded.
  - PREF: prefetch in flight; only with `PREFETCH_EN`.
- IDLE, `ioctl_rd` hits the cache: output the byte and stay in IDLE.
- IDLE, `ioctl_rd` misses: drive `port_a` and `port_ds`, toggle `port_req`, clear `ioctl_ready`, go to FETCH.
- FETCH, `port_ack==port_req`: write `port_q` into the cache, output the byte, set `ioctl_ready`, go to IDLE, or to PREF when prefetch is enabled.
- A new request is issued only when `port_ack==port_req`. This keeps toggle parity correct after reset.
- `ioctl_rd` during FETCH or PREF: latch it into a one-deep pending slot. A further `ioctl_rd` overwrites the slot (last one wins) and sets `rd_err`.
- The pending request is serviced on the cycle the machine returns to IDLE.
- `upload` falling edge:
  - clear `c_valid`, the prefetch valid bit and the pending slot;
  - an in-flight transfer moves to DRAIN, waits for the ack and discards the data;
  - `rd_err` clears on the next `upload` rising edge.
- `ioctl_rd` while `upload`=0 is ignored.

## Timing
- Reset values: `ioctl_din`=0, `ioctl_ready`=0, `rd_err`=0, `port_req`=0, `port_a`=0, `port_ds`=0, `port_we`=0, state IDLE, all valid bits 0.
- Hit: `ioctl_din` and `ioctl_ready` are valid 1 cycle after `ioctl_rd`.
- Miss:
  - `port_req` toggles 1 cycle after `ioctl_rd`;
  - `ioctl_ready` is low from that cycle;
  - data is valid and `ioctl_ready` is high 1 cycle after `port_ack` matches.
- `port_a`, `port_ds` and `port_req` are registered and held stable until ack.
- Reset mid-transfer: everything returns to reset values immediately. The block does not issue a request until `port_ack` equals `port_req` (0).

## Configuration
- `ROM_UPLOAD_PREFETCH_EN` defined:
  - after a demand fetch, automatically fetch word `c_addr+1` into a prefetch entry (PREF state);
  - a request hitting the prefetch entry promotes it to the cache with hit latency, then launches the next prefetch;
  - a word-address wrap at 23'h7FFFFF wraps to 0.
- Not defined: the PREF state and prefetch registers do not exist. Each new word costs one demand fetch.

## Structure
- Package `rom_upload_pkg`: state enum (IDLE, FETCH, DRAIN, PREF), `WORD_AW`=23, and a lane-select function.
- Sub-module `sdram_toggle_master`:
  - owns `port_req`, the busy comparison (`port_req != port_ack`) and the one-cycle `done` pulse;
  - the top handles caching, the pending slot and the FSM.

## Test plan
- Cold miss: `upload`=1, `ioctl_rd` at `ioctl_addr`=0x10 with `BASE_ADDR`=0 and SDRAM word 8 = 0xBEEF -> `port_a`=8, `port_ds`=2'b01, one toggle, `ioctl_din`=0xEF, ready 1 cycle after ack.
- Hit: next `ioctl_rd` at 0x11 -> no toggle, `ioctl_din`=0xBE one cycle later.
- Offset: `BASE_ADDR`=0xC000, `ioctl_addr`=0xC003 -> `port_a`=1, `port_ds`=2'b10, upper byte returned.
- Overflow: three `ioctl_rd` pulses during one 10-cycle ack delay -> the last address is serviced and `rd_err`=1 until the next `upload` rise.
- Abort: drop `upload` mid-fetch -> the ack is consumed and `ioctl_ready` stays 0. After re-entry, a read of the same address re-fetches it (one new toggle).
- Prefetch (macro on): read 0x00, 0x01, then 0x02 -> the word-1 fetch starts after word 0, and 0x02 returns with 1-cycle latency.
